// File: rtl/spi_single_pkg.sv
// Shared types and default constants for the single-lane SPI master family.
package spi_single_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } spi_state_e;

    localparam int unsigned DefDw    = 8;
    localparam int unsigned DefDivW  = 8;
    localparam int unsigned DefCsGap = 2;

endpackage

// File: rtl/spi_single_clkdiv.sv
// Half-period tick generator: counts 0..div and pulses tick on the terminal count.
module spi_single_clkdiv #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    assign tick = en && (cnt_q == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_single_xfer.sv
// Mode-0 SPI master between a FWFT TX FIFO read port and an RX FIFO write port.
// Back-to-back TX words share one CS-low window with no SCLK stretch.
module spi_single_xfer
    import spi_single_pkg::*;
#(
    parameter int unsigned DW     = DefDw,
    parameter int unsigned DIV_W  = DefDivW,
    parameter int unsigned CS_GAP = DefCsGap
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             tx_rne,
    input  logic [DW-1:0]    tx_rd,
    output logic             tx_rreq,
    input  logic             rx_wnf,
    output logic             rx_wreq,
    output logic [DW-1:0]    rx_wd,
    output logic             rx_drop,
    output logic             spi_csn,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             busy
);

    localparam int unsigned BW = (DW > 2) ? $clog2(DW) : 1;
    localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    spi_state_e       state_q;
    logic [DIV_W-1:0] div_q;
    logic [DW-1:0]    tx_sh_q;
    logic [DW-1:0]    rx_sh_q;
    logic [BW-1:0]    bitcnt_q;
    logic [GW-1:0]    gap_q;
    logic             tick;

    assign busy = (state_q != StIdle);

    spi_single_clkdiv #(
        .DIV_W (DIV_W)
    ) u_clkdiv (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .div  (div_q),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            div_q    <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            bitcnt_q <= '0;
            gap_q    <= '0;
            tx_rreq  <= 1'b0;
            rx_wreq  <= 1'b0;
            rx_wd    <= '0;
            rx_drop  <= 1'b0;
            spi_csn  <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            tx_rreq <= 1'b0;
            rx_wreq <= 1'b0;
            rx_drop <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tx_rne) begin
                        tx_rreq  <= 1'b1;
                        tx_sh_q  <= tx_rd;
                        spi_mosi <= tx_rd[DW-1];
                        div_q    <= cfg_div;
                        spi_csn  <= 1'b0;
                        spi_sclk <= 1'b0;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        bitcnt_q <= '0;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    if (tick) begin
                        spi_sclk <= ~spi_sclk;
                        if (!spi_sclk) begin
                            rx_sh_q <= {rx_sh_q[DW-2:0], spi_miso};
                        end else if (bitcnt_q == BW'(DW - 1)) begin
                            if (rx_wnf) begin
                                rx_wreq <= 1'b1;
                                rx_wd   <= rx_sh_q;
                            end else begin
                                rx_drop <= 1'b1;
                            end
                            // Chain the next word straight into the running SCLK.
                            if (tx_rne) begin
                                tx_rreq  <= 1'b1;
                                tx_sh_q  <= tx_rd;
                                spi_mosi <= tx_rd[DW-1];
                                bitcnt_q <= '0;
                            end else begin
                                state_q <= StHold;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + BW'(1);
                            tx_sh_q  <= tx_sh_q << 1;
                            spi_mosi <= tx_sh_q[DW-2];
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        spi_csn <= 1'b1;
                        gap_q   <= '0;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (tick) begin
                        if (gap_q == GW'(CS_GAP - 1)) begin
                            state_q <= StIdle;
                        end else begin
                            gap_q <= gap_q + GW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/spi_single_xfer.md
Name: spi_single_xfer

Overview:
- Single-lane SPI master (mode 0) that sits directly downstream of the FWFT dual-clock FIFO read port and upstream of a second FIFO's write port.
- Pops TX words from the FIFO and serialises them MSB-first on MOSI, holding CS low across back-to-back words.
- Deserialises MISO into RX words and pushes them to the RX FIFO.
- Runs entirely in the FIFO read-clock domain; no CDC inside the block.

Parameters:
- DW, 8, word width in bits (matches FIFO DW).
- DIV_W, 8, width of the clock-divider config.
- CS_GAP, 2, minimum CS-high time between frames, in SCLK half-periods (>=1).

Ports:
- clk  in  1  system clock (FIFO rclk domain)
- rst  in  1  asynchronous, active-high reset
- cfg_div  in  DIV_W  SCLK half-period = cfg_div+1 clk cycles
- tx_rne  in  1  TX FIFO not empty (FWFT: tx_rd valid while high)
- tx_rd  in  DW  TX FIFO head word
- tx_rreq  out  1  one-cycle pop pulse
- rx_wnf  in  1  RX FIFO not full
- rx_wreq  out  1  one-cycle push pulse
- rx_wd  out  DW  RX word, valid with rx_wreq
- rx_drop  out  1  one-cycle pulse: RX word discarded because RX FIFO was full
- spi_csn  out  1  chip select, active low
- spi_sclk  out  1  serial clock, idle low
- spi_mosi  out  1  master out
- spi_miso  in  1  master in (synchronous to the slave; no synchroniser here)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, asserts immediately; any state including mid-word):
  - Forces IDLE; spi_csn=1, spi_sclk=0, spi_mosi=0, tx_rreq=0, rx_wreq=0, rx_drop=0, rx_wd=0, busy=0.
  - The partial word is lost and no pop or push is issued.
- Divider:
  - Counter runs 0..div_q; tick is asserted when count==div_q, then the counter clears.
  - div_q is latched from cfg_div on IDLE->SETUP; cfg_div changes mid-frame are ignored.
  - The counter is held at 0 in IDLE.
- States and transitions:
  - IDLE: on tx_rne=1, pulse tx_rreq for 1 cycle, load shift reg <= tx_rd, latch div_q, go SETUP. The next cycle shows spi_csn=0 and spi_mosi=tx_rd[DW-1].
  - SETUP: one half-period with CS low and SCLK low; on tick go SHIFT with bitcnt=0.
  - SHIFT: each tick toggles SCLK.
    - Rising edge: sample spi_miso into the RX shift reg (LSB-in).
    - Falling edge: bitcnt++. If bitcnt<DW-1 (before increment), shift MOSI to the next bit.
  - Word end (the DW-th falling edge):
    - Push RX word: if rx_wnf=1, pulse rx_wreq with rx_wd; else pulse rx_drop.
    - If tx_rne=1 in that cycle: pulse tx_rreq, reload the shift reg, drive MOSI with the new MSB in the same cycle, and stay in SHIFT with bitcnt=0. SCLK continues with no gap and CS stays low.
    - Otherwise go HOLD.
  - HOLD: one half-period with CS low and SCLK low (tCSH); on tick set spi_csn=1 and go GAP.
  - GAP: CS_GAP half-periods with CS high; then go IDLE. tx_rne is ignored until IDLE.
- Timing:
  - A single word occupies exactly (2*DW+2)*(cfg_div+1) clk with CS low.
  - First-pop-to-CS-low latency is 1 clk.
- Boundaries:
  - cfg_div=0 is legal: SCLK=clk/2.
  - tx_rreq is never asserted while tx_rne=0.
  - rx_wreq is never asserted while rx_wnf=0.
  - A simultaneous RX push and TX pop in the same cycle is legal.
  - tx_rne deasserting between the pop and the next cycle has no effect on the current word.

Decomposition:
- Shared package spi_single_pkg holds:
  - The state enum (IDLE, SETUP, SHIFT, HOLD, GAP).
  - The default constants for DW, DIV_W and CS_GAP.
- One sub-module spi_single_clkdiv (DIV_W, en, div, tick), reusable by future SPI variants.
- The FSM and shift registers remain in the top module.

Test Plan:
- DW=8, cfg_div=1, single word 0xA5, MISO loopback -> MOSI bits 1,0,1,0,0,1,0,1 on rising edges; rx_wd=0xA5 with one rx_wreq; CS low for 18*2=36 clk; tx_rreq pulsed once.
- Three queued words 0x01,0x80,0xFF, cfg_div=0 -> single CS-low window, 24 contiguous SCLK periods with no stretch, 3 tx_rreq and 3 rx_wreq in order.
- rx_wnf=0 during word end, slave MISO=1 -> rx_drop pulses once, no rx_wreq, TX continues normally.
- cfg_div changed from 3 to 0 mid-frame -> the current frame keeps a 4-clk half-period; the next frame uses 1.
- rst asserted at bit 4 of a word -> same cycle spi_csn=1, sclk=0, busy=0; after release with tx_rne=1, a fresh frame starts from the FIFO head with no extra pop.
- CS_GAP=2, back-to-back frames separated by an empty FIFO -> CS high for at least 2*(cfg_div+1) clk before the next falling CS.
